serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 17 +
 rtl/serial_add_sub_fa.sv | 19 +
 rtl/serial_add_sub.sv | 108 ++++++++++
 tb/tb_serial_add_sub.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Purpose: shared ALU encodings for the bit-serial adder/subtractor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serial_add_sub_pkg;

    // Control state of the serial add/sub sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select carried on the 'sub' input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa.sv
// Purpose: one-bit full-adder cell, the only arithmetic in the serial ALU.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B operand bits; cin carry in; sum result bit; cout carry out.
module serial_add_sub_fa (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half;

    assign half = A ^ B;
    assign sum  = half ^ cin;
    assign cout = (A & B) | (cin & half);

endmodule

// File: rtl/serial_add_sub.sv
// Purpose: bit-serial WIDTH-bit add/subtract using a single full-adder cell.
// Latency: start edge plus WIDTH edges; done pulses after edge WIDTH, next start at WIDTH+2.
// Backpressure: none; start is only sampled in IDLE, requests in RUN/DONE are dropped.
// Ports: clk, rst (async, active-high); start/sub/a/b request; busy, done status;
//        result/cout/zero/ovf registered, updated only when an operation completes.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Sum shifter keeps only WIDTH-1 bits; the final bit comes straight from the cell.
    logic [WIDTH-2:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_nxt;

    serial_add_sub_fa u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; on the last bit this is the full result.
    assign s_nxt = {fa_sum, s_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: the +1 rides in on the initial carry.
                        a_sh  <= a;
                        b_sh  <= (sub == OP_ADD) ? b : ~b;
                        carry <= (sub == OP_SUB);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sh  <= s_nxt[WIDTH-1:1];
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_cout;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= s_nxt;
                        cout   <= fa_cout;
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        ovf    <= carry ^ fa_cout;
                        zero   <= (s_nxt == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    serial_add_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            exp_t got;
            got = '{res: result, c: cout, z: zero, o: ovf};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got res=%h c=%b z=%b o=%b, required no done pulse",
                         result, cout, zero, ovf);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result_check: got res=%h c=%b z=%b o=%b, required res=%h c=%b z=%b o=%b",
                             result, cout, zero, ovf, e.res, e.c, e.z, e.o);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_with_done: busy=%b, required 0", busy);
            end
        end
    end

    // Drive one request; returns at the negedge just after the start edge.
    task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        sub   = ~s;
    endtask

    // Issue, then wait for done, checking busy each cycle and the done latency.
    task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ec, input logic ez, input logic eo);
        int  lat;
        bit  busy_ok;
        exp_q.push_back('{res: er, c: ec, z: ez, o: eo});
        issue(s, av, bv);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (lat != W) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles after start edge, required %0d", lat, W);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL busy_window: busy dropped during RUN, required 1 throughout");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, cout, zero, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h c=%b z=%b o=%b, required all 0",
                     busy, done, result, cout, zero, ovf);
        end
        rst = 1'b0;

        // add 5+3
        run_op(1'b0, 32'd5, 32'd3, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        // sub 5-5
        run_op(1'b1, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

        // sub 0-1, checking the previous result holds mid-operation
        exp_q.push_back('{res: 32'hFFFF_FFFF, c: 1'b0, z: 1'b0, o: 1'b0});
        issue(1'b1, 32'd0, 32'd1);
        repeat (10) @(negedge clk);
        checks++;
        if ({result, cout, zero, ovf} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_during_run: got res=%h c=%b z=%b o=%b, required res=0 c=1 z=1 o=0",
                     result, cout, zero, ovf);
        end
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);

        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

        // Second start during RUN must be ignored.
        exp_q.push_back('{res: 32'h0000_001E, c: 1'b0, z: 1'b0, o: 1'b0});
        issue(1'b0, 32'd10, 32'd20);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignored_start_done: %0d expectations outstanding, required 0", exp_q.size());
        end

        // Reset in the middle of an add: outputs clear at once, no done follows.
        issue(1'b0, 32'd100, 32'd200);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, cout, zero, ovf} !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: got busy=%b done=%b res=%h c=%b z=%b o=%b, required all 0",
                     busy, done, result, cout, zero, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        run_op(1'b0, 32'd7, 32'd9, 32'h0000_0010, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
